// File: rtl/add_sub_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_sub_pkg : shared mode constants, FSM states and overflow helper
// Rev 1.0
// ---------------------------------------------------------------------------
package add_sub_pkg;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow from the operand MSBs and the result MSB.
    function automatic logic signed_ovf(input logic mode, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic w_ovf;
        if (mode == MODE_ADD)
            w_ovf = (a_msb == b_msb) && (r_msb != a_msb);
        else
            w_ovf = (a_msb != b_msb) && (r_msb != a_msb);
        return w_ovf;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub_digit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_sub_digit : combinational DIGIT-bit ripple add/sub slice
// Rev 1.0
// ---------------------------------------------------------------------------
module add_sub_digit
    import add_sub_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic w_c;
    logic w_x;

    always_comb begin
        w_c  = cin;
        w_x  = 1'b0;
        s    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_x  = a[i] ^ b[i];
            s[i] = w_x ^ w_c;
            if (en == MODE_ADD)
                w_c = (a[i] & b[i]) | (w_x & w_c);
            else
                w_c = (~a[i] & b[i]) | (~w_x & w_c);
        end
        cout = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/add_sub_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_sub_serial : digit-serial adder/subtractor with start/busy/done handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module add_sub_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = $clog2(NCYC) + 1;
    localparam logic [CW-1:0] c_last = CW'(NCYC - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic             r_carry;
    logic             r_amsb;
    logic             r_bmsb;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_ds;
    logic             w_dcout;
    logic [WIDTH-1:0] w_a_shr;
    logic [WIDTH-1:0] w_b_shr;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == c_last);

    add_sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .en   (r_mode),
        .s    (w_ds),
        .cout (w_dcout)
    );

    // New digits enter at the MSB end so the result is aligned after NCYC shifts.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_a_shr   = '0;
            assign w_b_shr   = '0;
            assign w_res_nxt = w_ds;
        end else begin : g_multi
            assign w_a_shr   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_shr   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_res_nxt = {w_ds, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == c_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_SUB;
            r_carry <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= en;
            r_carry <= cin;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= w_a_shr;
            r_b     <= w_b_shr;
            r_res   <= w_res_nxt;
            r_carry <= w_dcout;
            r_cnt   <= r_cnt + c_one;
            if (w_last) begin
                r_cout <= w_dcout;
                r_ovf  <= signed_ovf(r_mode, r_amsb, r_bmsb, w_ds[DIGIT-1]);
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_res;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_add_sub_serial : DIGIT=1,2,4,8 instances against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_add_sub_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;

    logic [3:0]      busy_v;
    logic [3:0]      done_v;
    logic [3:0][7:0] res_v;
    logic [3:0]      cout_v;
    logic [3:0]      ovf_v;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    // {ovf, cout, result} from plain integer arithmetic
    function automatic logic [9:0] calc(input logic add, input logic [7:0] x,
                                        input logic [7:0] y, input logic ci);
        int u;
        int s;
        logic [9:0] r;
        if (add) begin
            u = int'(x) + int'(y) + int'(ci);
            s = int'($signed(x)) + int'($signed(y)) + int'(ci);
            r[8] = (u > 255);
        end else begin
            u = int'(x) - int'(y) - int'(ci);
            s = int'($signed(x)) - int'($signed(y)) - int'(ci);
            r[8] = (u < 0);
        end
        r[7:0] = u[7:0];
        r[9]   = (s > 127) || (s < -128);
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int DG = 1 << i;
        localparam int NC = 8 / DG;

        add_sub_serial #(
            .WIDTH (8),
            .DIGIT (DG)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .en     (en),
            .a      (a),
            .b      (b),
            .cin    (cin),
            .busy   (busy_v[i]),
            .done   (done_v[i]),
            .result (res_v[i]),
            .cout   (cout_v[i]),
            .ovf    (ovf_v[i])
        );

        int         m_rem  = 0;
        logic       m_busy = 1'b0;
        logic       m_done = 1'b0;
        logic [7:0] m_res  = '0;
        logic       m_cout = 1'b0;
        logic       m_ovf  = 1'b0;
        logic [9:0] m_pend = '0;

        always @(posedge clk) begin
            if (rst) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
                m_res  <= '0;
                m_cout <= 1'b0;
                m_ovf  <= 1'b0;
                m_rem  <= 0;
            end else begin
                m_done <= 1'b0;
                if (m_busy) begin
                    if (m_rem == 1) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                        m_res  <= m_pend[7:0];
                        m_cout <= m_pend[8];
                        m_ovf  <= m_pend[9];
                    end
                    m_rem <= m_rem - 1;
                end else if (start) begin
                    m_busy <= 1'b1;
                    m_rem  <= NC;
                    m_pend <= calc(en, a, b, cin);
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk("busy", i, int'(busy_v[i]), int'(m_busy));
                chk("done", i, int'(done_v[i]), int'(m_done));
                if (!m_busy) begin
                    chk("result", i, int'(res_v[i]), int'(m_res));
                    chk("cout", i, int'(cout_v[i]), int'(m_cout));
                    chk("ovf", i, int'(ovf_v[i]), int'(m_ovf));
                end
            end
        end
    end

    // Directed op on the DIGIT=2 instance with literal expectations.
    task automatic run_op(input string name, input logic m, input logic [7:0] x,
                          input logic [7:0] y, input logic ci, input logic inject,
                          input logic [7:0] e_res, input logic e_cout, input logic e_ovf);
        int cyc;
        @(negedge clk);
        start = 1'b1; en = m; a = x; b = y; cin = ci;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done_v[1] && cyc < 20) begin
            if (inject && cyc == 2) begin
                start = 1'b1; en = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({name, "_latency"}, 1, cyc, 5);
        chk({name, "_result"}, 1, int'(res_v[1]), int'(e_res));
        chk({name, "_cout"}, 1, int'(cout_v[1]), int'(e_cout));
        chk({name, "_ovf"}, 1, int'(ovf_v[1]), int'(e_ovf));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", 1, int'(busy_v[1]), 0);
        chk("reset_done", 1, int'(done_v[1]), 0);
        chk("reset_result", 1, int'(res_v[1]), 0);
        chk("reset_cout", 1, int'(cout_v[1]), 0);
        chk("reset_ovf", 1, int'(ovf_v[1]), 0);

        run_op("add_ff_01", 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01", 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_10_20c", 1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        run_op("sub_00_01", 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("sub_80_01", 1'b0, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("ignore_mid", 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("ghost_done", 1, int'(done_v[1]), 0);
        end

        // Reset in the middle of an operation
        start = 1'b1; en = 1'b1; a = 8'h55; b = 8'h0F; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 1, int'(busy_v[1]), 0);
        chk("midrst_result", 1, int'(res_v[1]), 0);
        chk("midrst_done", 1, int'(done_v[1]), 0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_nodone", 1, int'(done_v[1]), 0);
        end

        // Reset and start together
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", 1, int'(busy_v[1]), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", 1, int'(busy_v[1]), 0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 2) != 0);
            en    = 1'($urandom_range(0, 1));
            cin   = 1'($urandom_range(0, 1));
            a     = 8'($urandom);
            b     = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
